// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR ADC sequencer.
//   sar_state_e   : sequencer state encoding (IDLE/SAMPLE/CONVERT/DONE)
//   DEF_*         : default resolution, channel count and timing
//   clog2_min1/chw: counter and channel-select width helpers
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_e;

  localparam int unsigned DEF_WIDTH         = 8;
  localparam int unsigned DEF_NUM_CH        = 4;
  localparam int unsigned DEF_SAMPLE_CYCLES = 2;
  localparam int unsigned DEF_SETTLE_CYCLES = 1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 32'd1 : int'($clog2(n));
  endfunction

  // Channel-select width for a given channel count.
  function automatic int unsigned chw(input int unsigned num_ch);
    return clog2_min1(num_ch);
  endfunction

endpackage

// File: rtl/sar_seq_ctrl_if.sv
// Bundle between the SAR sequencer, the analog front end and the result consumer.
//   master : sequencer side (drives track/DAC/strobe/mux and the result channel)
//   slave  : front end + consumer side (drives Start/ScanEn/ChSelIn/Compare/DataReady)
interface sar_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHW   = 2
);

  logic             Start;
  logic             ScanEn;
  logic [CHW-1:0]   ChSelIn;
  logic             Compare;
  logic             Busy;
  logic             SampleEn;
  logic             CmpStrobe;
  logic [WIDTH-1:0] SAROut;
  logic [CHW-1:0]   ChSel;
  logic [WIDTH-1:0] DataOut;
  logic [CHW-1:0]   DataCh;
  logic             DataValid;
  logic             DataReady;

  modport master (
    input  Start, ScanEn, ChSelIn, Compare, DataReady,
    output Busy, SampleEn, CmpStrobe, SAROut, ChSel, DataOut, DataCh, DataValid
  );

  modport slave (
    output Start, ScanEn, ChSelIn, Compare, DataReady,
    input  Busy, SampleEn, CmpStrobe, SAROut, ChSel, DataOut, DataCh, DataValid
  );

endinterface

// File: rtl/sar_bit_engine.sv
// Successive-approximation bit engine: trial register, bit pointer and settle
// counter. A go pulse loads the MSB trial; each bit holds for SETTLE_CYCLES
// clocks with strobe on the last one, where compare resolves the bit.
//   clk, rst_n : clock, synchronous active-low reset
//   go         : load MSB trial and start a conversion
//   compare    : comparator decision, used only while strobe=1
//   sar        : current DAC trial code (0 when idle)
//   strobe     : comparator latch strobe
//   done_c     : final bit being resolved this cycle
//   result_c   : trial code with the current bit resolved by compare
module sar_bit_engine
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             compare,
  output logic [WIDTH-1:0] sar,
  output logic             strobe,
  output logic             done_c,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned PW = clog2_min1(WIDTH);
  localparam int unsigned CW = clog2_min1(SETTLE_CYCLES);
  localparam logic        STROBE_ON_ENTRY = (SETTLE_CYCLES == 1);

  logic             active;
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] bit_mask_c;

  // One-hot mask of the bit under test; shifting it right gives the next trial bit.
  assign bit_mask_c = WIDTH'(1) << ptr;
  assign result_c   = compare ? sar : (sar & ~bit_mask_c);
  assign done_c     = active && strobe && (ptr == '0);

  // Trial/pointer/settle sequencing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active <= 1'b0;
      sar    <= '0;
      ptr    <= PW'(WIDTH - 1);
      cnt    <= '0;
      strobe <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      sar    <= WIDTH'(1) << (WIDTH - 1);
      ptr    <= PW'(WIDTH - 1);
      cnt    <= '0;
      strobe <= STROBE_ON_ENTRY;
    end else if (active) begin
      if (strobe) begin
        cnt <= '0;
        if (ptr == '0) begin
          active <= 1'b0;
          sar    <= '0;
          ptr    <= PW'(WIDTH - 1);
          strobe <= 1'b0;
        end else begin
          sar    <= result_c | (bit_mask_c >> 1);
          ptr    <= ptr - PW'(1);
          strobe <= STROBE_ON_ENTRY;
        end
      end else begin
        cnt    <= cnt + CW'(1);
        strobe <= ((32'(cnt) + 32'd1) == (SETTLE_CYCLES - 32'd1));
      end
    end
  end

endmodule

// File: rtl/sar_seq_ctrl.sv
// SAR ADC sequencer: IDLE -> SAMPLE (track) -> CONVERT (bit engine) -> DONE
// (valid/ready result), with single or auto-scan channel selection.
//   Clock, ResetN : clock, synchronous active-low reset
//   bus (master)  : Start/ScanEn/ChSelIn/Compare/DataReady in;
//                   Busy/SampleEn/CmpStrobe/SAROut/ChSel/DataOut/DataCh/DataValid out
module sar_seq_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned NUM_CH        = DEF_NUM_CH,
  parameter int unsigned SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic          Clock,
  input  logic          ResetN,
  sar_seq_ctrl_if.master bus
);

  localparam int unsigned CHW = chw(NUM_CH);
  localparam int unsigned SW  = clog2_min1(SAMPLE_CYCLES);

  sar_state_e       state;
  logic [SW-1:0]    smp_cnt;
  logic             go_c;
  logic             done_c;
  logic [WIDTH-1:0] result_c;
  logic [WIDTH-1:0] sar;
  logic             strobe;
  logic [CHW-1:0]   ch_next_c;

  assign go_c = (state == SAMPLE) && (smp_cnt == SW'(SAMPLE_CYCLES - 1));

  // Scan wraps at the last populated channel so unused mux codes are never driven.
  assign ch_next_c = (bus.ChSel == CHW'(NUM_CH - 1)) ? '0 : bus.ChSel + CHW'(1);

  sar_bit_engine #(
    .WIDTH        (WIDTH),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_engine (
    .clk     (Clock),
    .rst_n   (ResetN),
    .go      (go_c),
    .compare (bus.Compare),
    .sar     (sar),
    .strobe  (strobe),
    .done_c  (done_c),
    .result_c(result_c)
  );

  assign bus.SAROut    = sar;
  assign bus.CmpStrobe = strobe;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state         <= IDLE;
      smp_cnt       <= '0;
      bus.Busy      <= 1'b0;
      bus.SampleEn  <= 1'b0;
      bus.ChSel     <= '0;
      bus.DataOut   <= '0;
      bus.DataCh    <= '0;
      bus.DataValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            state        <= SAMPLE;
            smp_cnt      <= '0;
            bus.Busy     <= 1'b1;
            bus.SampleEn <= 1'b1;
            bus.ChSel    <= bus.ChSelIn;
          end
        end
        SAMPLE: begin
          if (go_c) begin
            state        <= CONVERT;
            bus.SampleEn <= 1'b0;
          end else begin
            smp_cnt <= smp_cnt + SW'(1);
          end
        end
        CONVERT: begin
          if (done_c) begin
            state         <= DONE;
            bus.DataOut   <= result_c;
            bus.DataCh    <= bus.ChSel;
            bus.DataValid <= 1'b1;
          end
        end
        DONE: begin
          // ScanEn is looked at only on the accepting edge.
          if (bus.DataValid && bus.DataReady) begin
            bus.DataValid <= 1'b0;
            if (bus.ScanEn) begin
              state        <= SAMPLE;
              smp_cnt      <= '0;
              bus.SampleEn <= 1'b1;
              bus.ChSel    <= ch_next_c;
            end else begin
              state    <= IDLE;
              bus.Busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_seq_ctrl.sv
// Self-checking bench for sar_seq_ctrl: three builds (8-bit defaults,
// 12-bit/3-channel, 8-bit with 3-cycle settle) driven by an ideal comparator.
module tb_sar_seq_ctrl;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   tests;
  int   fails;

  sar_seq_ctrl_if #(.WIDTH(8),  .CHW(2)) bus_a ();
  sar_seq_ctrl_if #(.WIDTH(12), .CHW(2)) bus_b ();
  sar_seq_ctrl_if #(.WIDTH(8),  .CHW(2)) bus_c ();

  sar_seq_ctrl #(.WIDTH(8), .NUM_CH(4), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1))
    dut_a (.Clock(clk), .ResetN(rst_a), .bus(bus_a));
  sar_seq_ctrl #(.WIDTH(12), .NUM_CH(3), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1))
    dut_b (.Clock(clk), .ResetN(rst_b), .bus(bus_b));
  sar_seq_ctrl #(.WIDTH(8), .NUM_CH(4), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3))
    dut_c (.Clock(clk), .ResetN(rst_b), .bus(bus_c));

  // Ideal comparators: Compare = (Vin >= DAC code)
  logic [7:0]  vin_a;
  logic [7:0]  vin_c;
  logic [11:0] vin_b [3];

  assign bus_a.Compare = (vin_a >= bus_a.SAROut);
  assign bus_b.Compare = (bus_b.ChSel < 2'd3) ? (vin_b[bus_b.ChSel] >= bus_b.SAROut) : 1'b0;
  assign bus_c.Compare = (vin_c >= bus_c.SAROut);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Trial codes seen at each strobe of build A, and illegal channel codes on build B
  logic [7:0] trial_log [$];
  int         bad_ch;
  initial bad_ch = 0;
  always @(negedge clk) begin
    if (bus_a.CmpStrobe) trial_log.push_back(bus_a.SAROut);
    if (bus_b.ChSel == 2'd3) bad_ch++;
  end

  typedef struct {
    logic [7:0] vin;
    logic [1:0] ch;
    logic [7:0] exp_out;
    logic [1:0] exp_ch;
    int         exp_lat;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_trials [8];
  logic       stb_c [64];
  logic [7:0] sar_c [64];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_a(input logic [7:0] v, input logic [1:0] ch, output int lat, output int base);
    @(negedge clk);
    vin_a = v; bus_a.ChSelIn = ch; bus_a.ScanEn = 1'b0; bus_a.DataReady = 1'b1; bus_a.Start = 1'b1;
    @(posedge clk); #1;
    bus_a.Start = 1'b0;
    base = trial_log.size();
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus_a.DataValid) begin lat = n; break; end
    end
  endtask

  task automatic start_b(input logic [1:0] ch, input logic scan, input logic rdy);
    @(negedge clk);
    bus_b.ChSelIn = ch; bus_b.ScanEn = scan; bus_b.DataReady = rdy; bus_b.Start = 1'b1;
    @(posedge clk); #1;
    bus_b.Start = 1'b0;
  endtask

  task automatic wait_valid_b(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus_b.DataValid) begin lat = n; break; end
    end
  endtask

  initial begin
    int lat;
    int base;
    int viol;
    logic [11:0] scan_out [4];
    logic [1:0]  scan_ch [4];

    tests = 0; fails = 0;
    vecs[0] = '{8'hA5, 2'd2, 8'hA5, 2'd2, 10};
    vecs[1] = '{8'h00, 2'd0, 8'h00, 2'd0, 10};
    vecs[2] = '{8'hFF, 2'd3, 8'hFF, 2'd3, 10};
    vecs[3] = '{8'h5A, 2'd1, 8'h5A, 2'd1, 10};
    vecs[4] = '{8'h80, 2'd0, 8'h80, 2'd0, 10};
    vecs[5] = '{8'h7F, 2'd2, 8'h7F, 2'd2, 10};
    exp_trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    scan_out = '{12'h020, 12'h030, 12'h010, 12'h020};
    scan_ch  = '{2'd1, 2'd2, 2'd0, 2'd1};

    vin_a = '0; vin_c = '0;
    vin_b[0] = 12'h010; vin_b[1] = 12'h020; vin_b[2] = 12'h030;
    bus_a.Start = 0; bus_a.ScanEn = 0; bus_a.ChSelIn = '0; bus_a.DataReady = 0;
    bus_b.Start = 0; bus_b.ScanEn = 0; bus_b.ChSelIn = '0; bus_b.DataReady = 0;
    bus_c.Start = 0; bus_c.ScanEn = 0; bus_c.ChSelIn = '0; bus_c.DataReady = 0;
    rst_a = 0; rst_b = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_flags", int'({bus_a.Busy, bus_a.SampleEn, bus_a.CmpStrobe, bus_a.DataValid}), 0);
    chk("rst_a_sarout", int'(bus_a.SAROut), 0);
    chk("rst_a_data", int'({bus_a.DataOut, bus_a.DataCh, bus_a.ChSel}), 0);
    chk("rst_b_flags", int'({bus_b.Busy, bus_b.SampleEn, bus_b.CmpStrobe, bus_b.DataValid}), 0);
    @(negedge clk);
    rst_a = 1; rst_b = 1;

    // Build A: single conversions from the vector table
    for (int i = 0; i < 6; i++) begin
      run_a(vecs[i].vin, vecs[i].ch, lat, base);
      chk($sformatf("a%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("a%0d_dataout", i), int'(bus_a.DataOut), int'(vecs[i].exp_out));
      chk($sformatf("a%0d_datach", i), int'(bus_a.DataCh), int'(vecs[i].exp_ch));
      chk($sformatf("a%0d_strobes", i), trial_log.size() - base, 8);
      if (i == 0) begin
        for (int k = 0; k < 8; k++)
          if (base + k < trial_log.size())
            chk($sformatf("a0_trial%0d", k), int'(trial_log[base + k]), int'(exp_trials[k]));
      end
      @(posedge clk); #1;
      chk($sformatf("a%0d_idle_after", i), int'({bus_a.Busy, bus_a.DataValid}), 0);
    end

    // Build A: reset while bit 4 is on trial, then a fresh conversion
    @(negedge clk);
    vin_a = 8'h3C; bus_a.ChSelIn = 2'd1; bus_a.Start = 1'b1;
    @(posedge clk); #1;
    bus_a.Start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midrst_bit4_trial", int'(bus_a.SAROut), 8'h30);
    chk("midrst_bit4_strobe", int'(bus_a.CmpStrobe), 1);
    rst_a = 0;
    @(posedge clk); #1;
    chk("midrst_flags", int'({bus_a.Busy, bus_a.SampleEn, bus_a.CmpStrobe, bus_a.DataValid}), 0);
    chk("midrst_sarout", int'(bus_a.SAROut), 0);
    chk("midrst_data", int'({bus_a.DataOut, bus_a.DataCh, bus_a.ChSel}), 0);
    @(negedge clk);
    rst_a = 1;
    run_a(8'h3C, 2'd1, lat, base);
    chk("postrst_latency", lat, 10);
    chk("postrst_dataout", int'(bus_a.DataOut), 8'h3C);
    chk("postrst_datach", int'(bus_a.DataCh), 1);

    // Build B: 12-bit single conversion
    vin_b[2] = 12'hABC;
    start_b(2'd2, 1'b0, 1'b1);
    wait_valid_b(lat);
    chk("b12_latency", lat, 14);
    chk("b12_dataout", int'(bus_b.DataOut), 12'hABC);
    chk("b12_datach", int'(bus_b.DataCh), 2);
    vin_b[2] = 12'h030;
    repeat (2) @(posedge clk);

    // Build B: scan from channel 1 over 3 channels, ScanEn dropped during the 4th
    start_b(2'd1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        @(posedge clk); #1;
        bus_b.ScanEn = 1'b0;
      end
      wait_valid_b(lat);
      chk($sformatf("scan%0d_latency", k), lat, (k == 1 || k == 2) ? 15 : 14);
      chk($sformatf("scan%0d_datach", k), int'(bus_b.DataCh), int'(scan_ch[k]));
      chk($sformatf("scan%0d_dataout", k), int'(bus_b.DataOut), int'(scan_out[k]));
    end
    @(posedge clk); #1;
    chk("scan_stop_idle", int'({bus_b.Busy, bus_b.SampleEn}), 0);

    // Build B: back-pressure while in DONE
    start_b(2'd0, 1'b1, 1'b0);
    wait_valid_b(lat);
    chk("bp_latency", lat, 14);
    viol = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus_b.DataOut != 12'h010 || bus_b.DataCh != 2'd0 || !bus_b.DataValid ||
          bus_b.SampleEn || !bus_b.Busy) viol++;
    end
    chk("bp_hold_violations", viol, 0);
    @(negedge clk);
    bus_b.DataReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_sample", int'({bus_b.SampleEn, bus_b.DataValid}), 2'b10);
    chk("bp_release_ch", int'(bus_b.ChSel), 1);
    bus_b.ScanEn = 1'b0;
    wait_valid_b(lat);
    chk("bp_next_latency", lat, 14);
    chk("bp_next_dataout", int'(bus_b.DataOut), 12'h020);
    chk("bp_next_datach", int'(bus_b.DataCh), 1);
    @(posedge clk); #1;
    chk("bp_end_idle", int'(bus_b.Busy), 0);
    chk("b_unused_ch_code", bad_ch, 0);

    // Build C: 3-cycle settle, Start pulsed mid-CONVERT
    @(negedge clk);
    vin_c = 8'h5B; bus_c.ChSelIn = 2'd3; bus_c.ScanEn = 1'b0; bus_c.DataReady = 1'b1; bus_c.Start = 1'b1;
    @(posedge clk); #1;
    bus_c.Start = 1'b0;
    lat = -1;
    for (int n = 1; n < 64; n++) begin
      @(posedge clk); #1;
      stb_c[n] = bus_c.CmpStrobe;
      sar_c[n] = bus_c.SAROut;
      bus_c.Start = (n == 10);
      if (bus_c.DataValid) begin lat = n; break; end
    end
    bus_c.Start = 1'b0;
    chk("c_latency", lat, 26);
    chk("c_dataout", int'(bus_c.DataOut), 8'h5B);
    chk("c_datach", int'(bus_c.DataCh), 3);
    if (lat > 0) begin
      viol = 0;
      for (int n = 1; n <= lat; n++)
        if (stb_c[n] != (n >= 2 && n <= 25 && (n - 2) % 3 == 2)) viol++;
      chk("c_strobe_pattern", viol, 0);
      viol = 0;
      for (int n = 3; n <= 25 && n <= lat; n++)
        if ((n - 2) % 3 != 0 && sar_c[n] != sar_c[n - 1]) viol++;
      chk("c_sarout_window_stable", viol, 0);
      chk("c_sarout_sample", int'(sar_c[1]), 0);
      chk("c_sarout_first", int'(sar_c[2]), 8'h80);
      chk("c_sarout_done", int'(sar_c[lat]), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("c_start_ignored_idle", int'({bus_c.Busy, bus_c.SampleEn}), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
